ahir_pipe_fifo: RTL

- Elastic buffer placed directly on the AHIR pipe interface of the RIFFA-to-AHIR bridge.
  - Its write side is driven by the bridge's in_data_pipe write_req/write_data.
  - Its read side feeds the AHIR system's input pipe.
  - The same module is instantiated mirrored on the out_data_pipe path.
- Decouples RIFFA burst timing from AHIR pipe consumption, so RX data is not stalled word-by-word by the AHIR core.
- Reports occupancy and watermark status, and supports a synchronous flush between transactions.

---
 rtl/ahir_pipe_fifo_pkg.sv | 19 +
 rtl/ahir_pipe_fifo_if.sv | 27 ++
 rtl/ahir_pipe_fifo_mem.sv | 29 ++
 rtl/ahir_pipe_fifo.sv | 113 +++++++++++
 4 files changed

// File: rtl/ahir_pipe_fifo_pkg.sv
// Shared definitions for the AHIR pipe elastic buffer: default word width,
// word type and a constant-foldable ceiling log2.
package ahir_pipe_pkg;

    localparam int unsigned C_PCI_DATA_WIDTH_DFLT = 32;

    typedef logic [C_PCI_DATA_WIDTH_DFLT-1:0] word_t;

    // Smallest n with 2**n >= v; usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 1; i < v; i = i * 2) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/ahir_pipe_fifo_if.sv
// Pipe-side bundle of the elastic buffer: write/read handshakes, flush and
// status. The FIFO is the slave; the bridge/testbench side is the master.
interface ahir_pipe_fifo_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 4
);
    logic          flush;
    logic          write_req;
    logic [W-1:0]  write_data;
    logic          write_ack;
    logic          read_req;
    logic [W-1:0]  read_data;
    logic          read_ack;
    logic [AW:0]   occupancy;
    logic          almost_full;
    logic          overflow_err;

    modport master (
        output flush, write_req, write_data, read_req,
        input  write_ack, read_data, read_ack, occupancy, almost_full, overflow_err
    );

    modport slave (
        input  flush, write_req, write_data, read_req,
        output write_ack, read_data, read_ack, occupancy, almost_full, overflow_err
    );
endinterface

// File: rtl/ahir_pipe_fifo_mem.sv
// Register-file storage: one synchronous write port, one asynchronous read
// port, no reset (contents are only meaningful behind the FIFO pointers).
module ahir_pipe_fifo_mem
    import ahir_pipe_pkg::*;
#(
    parameter int unsigned W      = C_PCI_DATA_WIDTH_DFLT,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    // Store the incoming word on a write beat.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahir_pipe_fifo.sv
// Elastic buffer on an AHIR pipe: decouples producer burst timing from
// consumer pace, reports occupancy/watermark, sticky overflow, sync flush.
module ahir_pipe_fifo
    import ahir_pipe_pkg::*;
#(
    parameter int unsigned C_PCI_DATA_WIDTH = C_PCI_DATA_WIDTH_DFLT,
    parameter int unsigned DEPTH            = 16,
    parameter int unsigned ALMOST_FULL_LVL  = DEPTH - 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    ahir_pipe_fifo_if.slave pipe
);

    localparam int unsigned       ADDR_W  = clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AF_LVL  = ALMOST_FULL_LVL[ADDR_W:0];

    logic [ADDR_W-1:0]           wr_ptr;
    logic [ADDR_W-1:0]           rd_ptr;
    logic [ADDR_W:0]             count_q;
    logic [ADDR_W:0]             count_d;
    logic                        af_q;
    logic                        ovf_q;
    logic [C_PCI_DATA_WIDTH-1:0] last_q;
    logic [C_PCI_DATA_WIDTH-1:0] head;
    logic                        full;
    logic                        empty;
    logic                        wr_beat;
    logic                        rd_beat;

    // Full/empty come from the count register only, so acks never see req.
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign wr_beat = pipe.write_req & ~full;
    assign rd_beat = pipe.read_req & ~empty;

    ahir_pipe_fifo_mem #(
        .W      (C_PCI_DATA_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (wr_beat & ~pipe.flush),
        .waddr (wr_ptr),
        .wdata (pipe.write_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Next occupancy: +1 write only, -1 read only, else unchanged.
    always_comb begin
        count_d = count_q;
        if (wr_beat && !rd_beat) begin
            count_d = count_q + 1'b1;
        end else if (rd_beat && !wr_beat) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers, count and watermark; flush overrides both beats.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            af_q    <= 1'b0;
        end else if (pipe.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            af_q    <= 1'b0;
        end else begin
            if (wr_beat) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_beat) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_d;
            af_q    <= (count_d >= AF_LVL);
        end
    end

    // Sticky overflow: write offered while full; cleared only by flush/reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
        end else if (pipe.flush) begin
            ovf_q <= 1'b0;
        end else if (pipe.write_req && full) begin
            ovf_q <= 1'b1;
        end
    end

    // Remember the last consumed word so read_data holds it while empty
    // and reads as zero straight out of reset (storage itself has no reset).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_q <= '0;
        end else if (rd_beat && !pipe.flush) begin
            last_q <= head;
        end
    end

    assign pipe.write_ack    = ~full;
    assign pipe.read_ack     = ~empty;
    assign pipe.read_data    = empty ? last_q : head;
    assign pipe.occupancy    = count_q;
    assign pipe.almost_full  = af_q;
    assign pipe.overflow_err = ovf_q;

endmodule
